userio_osd_cmd: RTL and testbench
=================================

# userio_osd_cmd

OSD command decoder sitting directly downstream of the OSD SPI slave. It consumes the slave's received-byte stream (byte, first-byte flag, byte strobe, chip-select valid) and turns command and data bytes into side effects:
- OSD character-buffer RAM writes, including a hardware row-clear engine
- OSD control registers
- keyboard-code injection

It also drives the slave's parallel input with a live status byte that the host reads out.

## Interface
Parameters:
- ID, 3'b101, identification field returned in status bits [7:5]

Ports:
- clk  in  1  pixel clock; all logic on posedge
- reset  in  1  synchronous, active-high
- clk7_en  in  1  clock enable; qualifies all SPI-side inputs
- spi_vld  in  1  chip-select valid from SPI slave (high = selected)
- spi_rx  in  1  byte-received flag, held for one clk7_en period
- spi_cmd  in  1  high when current byte is first after select
- spi_byte  in  8  received byte
- spi_in  out  8  status byte to SPI slave parallel input
- ram_wr  out  1  OSD RAM write strobe, one clk wide
- ram_addr  out  11  {row[2:0], col[7:0]}
- ram_data  out  8  write data
- osd_enable  out  1  OSD display enable
- hilite_en  out  1  highlight bar enable
- hilite_row  out  3  highlighted row
- key_code  out  8  injected keyboard code
- key_strobe  out  1  one-clk pulse per injected key

## Operation
- Byte event `ev` = spi_rx & clk7_en. The event is a command if spi_cmd=1, otherwise data.
- Command map on a command event. The decoder enters the listed state.
  - 0x20–0x27 → WROW: row = cmd[2:0], col = 0.
  - 0x28–0x2F → CLEAR: row = cmd[2:0], starts the clear engine.
  - 0x40 → CTRL.
  - 0x41 → HROW.
  - 0x60 → KEY.
  - 0x81 → clears the overrun flag, then IGNORE.
  - All other values → IGNORE.
- Data events by state:
  - WROW: write spi_byte to {row, col}, then col += 1. col wraps 255→0 and row is unchanged.
  - CTRL: first data byte sets osd_enable = b0 and hilite_en = b1. Later bytes are ignored.
  - HROW: first data byte sets hilite_row = b[2:0]. Later bytes are ignored.
  - KEY: every data byte drives key_code = byte and pulses key_strobe.
  - IGNORE / IDLE: data is dropped.
- Clear engine:
  - Writes 0x00 to {row, 0..255}, one write per clk, with no clk7_en gating: 256 consecutive ram_wr cycles.
  - Status bit `clearing` is high while the engine is active.
  - It then returns to IGNORE.
  - Any byte event (command or data) arriving while clearing is dropped and sets the sticky `overrun` flag.
- Deselect: on clk7_en with spi_vld=0, the state goes to IDLE.
  - A running clear still completes.
  - The control registers keep their values.
- spi_in is combinational from registers: {ID, overrun, clearing, hilite_en, osd_enable, 1'b0}.

## Timing
- Reset values:
  - state IDLE, clear engine idle.
  - ram_wr = 0, ram_addr = 0, ram_data = 0.
  - osd_enable = 0, hilite_en = 0, hilite_row = 0.
  - key_code = 0, key_strobe = 0, overrun = 0.
  - spi_in = {ID, 5'b00000}.
- Reset mid-clear aborts the clear immediately; no further ram_wr.
- Data write: ram_wr/ram_addr/ram_data are registered and asserted on the clk after the ev cycle, for exactly 1 clk.
- CTRL/HROW register updates and key_strobe appear on the clk after ev. key_strobe is 1 clk wide.
- Clear: first ram_wr (col 0) is on the clk after the ev. The last ram_wr (col 255) is 256 clks after it.
  - `clearing` is high from the clk after ev through the last write cycle, then drops.
- Because spi_rx spans one clk7_en period, each byte produces exactly one ev. No double writes.
- If ev and spi_vld=0 occur in the same clk7_en cycle, ev is processed first. A command byte's decode is overridden by IDLE.
- A command event while in any state (except clearing) re-decodes immediately. Any pending col/first-byte state is discarded.

## Test plan
- Reset, then select. Send 0x23, 0x41, 0x42 → ram_wr at addr 0x300 data 0x41, then addr 0x301 data 0x42, each 1 clk wide, one clk after ev.
- Send 0x20 then 258 data bytes (byte n = n[7:0]) → addr cycles 0x000..0x0FF, then 0x000 and 0x001. Writes 256 and 257 overwrite cols 0 and 1 with 0x00, 0x01.
- Send 0x40, 0x03, 0x00 → osd_enable=1, hilite_en=1, unchanged by the third byte. spi_in = 0xA6 (default ID).
- Send 0x2D → 256 consecutive writes of 0x00 to 0x500..0x5FF. Send 0x41 during the clear → dropped, spi_in bit4 set. Send 0x81 → bit4 cleared.
- Send 0x60, 0x45, 0x12 → key_code 0x45 then 0x12, two 1-clk key_strobe pulses. Deassert spi_vld, then reselect and send a data byte → no strobe, no write.
- Assert reset mid-clear at col 0x40 → ram_wr stops next clk and all outputs return to their reset values.

Source files
------------

// File: rtl/userio_osd_cmd.sv
// OSD command decoder: turns SPI slave byte events into OSD RAM writes,
// control register updates, keyboard-code injection and a row-clear engine.
module userio_osd_cmd #(
    parameter logic [2:0] ID = 3'b101
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic        spi_vld,
    input  logic        spi_rx,
    input  logic        spi_cmd,
    input  logic [7:0]  spi_byte,
    output logic [7:0]  spi_in,
    output logic        ram_wr,
    output logic [10:0] ram_addr,
    output logic [7:0]  ram_data,
    output logic        osd_enable,
    output logic        hilite_en,
    output logic [2:0]  hilite_row,
    output logic [7:0]  key_code,
    output logic        key_strobe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WROW,
        S_CLEAR,
        S_CTRL,
        S_HROW,
        S_KEY,
        S_IGNORE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  row_q, row_d;
    logic [7:0]  col_q, col_d;
    logic        first_q, first_d;
    logic        clearing_q, clearing_d;
    logic        overrun_q, overrun_d;
    logic        ram_wr_q, ram_wr_d;
    logic [10:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_data_q, ram_data_d;
    logic        osd_enable_q, osd_enable_d;
    logic        hilite_en_q, hilite_en_d;
    logic [2:0]  hilite_row_q, hilite_row_d;
    logic [7:0]  key_code_q, key_code_d;
    logic        key_strobe_q, key_strobe_d;
    logic        ev;

    assign ev = spi_rx & clk7_en;

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        first_d      = first_q;
        clearing_d   = clearing_q;
        overrun_d    = overrun_q;
        ram_wr_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;
        osd_enable_d = osd_enable_q;
        hilite_en_d  = hilite_en_q;
        hilite_row_d = hilite_row_q;
        key_code_d   = key_code_q;
        key_strobe_d = 1'b0;

        if (clearing_q) begin
            // ram_addr_q doubles as the clear cursor: it holds the column just written.
            if (ram_addr_q[7:0] == 8'hFF) begin
                clearing_d = 1'b0;
                if (state_q == S_CLEAR) state_d = S_IGNORE;
            end else begin
                ram_wr_d   = 1'b1;
                ram_addr_d = ram_addr_q + 11'd1;
                ram_data_d = '0;
            end
            if (ev) overrun_d = 1'b1;
        end else if (ev) begin
            if (spi_cmd) begin
                first_d = 1'b1;
                col_d   = '0;
                state_d = S_IGNORE;
                if (spi_byte[7:3] == 5'b00100) begin
                    state_d = S_WROW;
                    row_d   = spi_byte[2:0];
                end else if (spi_byte[7:3] == 5'b00101) begin
                    state_d    = S_CLEAR;
                    clearing_d = 1'b1;
                    ram_wr_d   = 1'b1;
                    ram_addr_d = {spi_byte[2:0], 8'h00};
                    ram_data_d = '0;
                end else begin
                    case (spi_byte)
                        8'h40:   state_d = S_CTRL;
                        8'h41:   state_d = S_HROW;
                        8'h60:   state_d = S_KEY;
                        8'h81:   overrun_d = 1'b0;
                        default: ;
                    endcase
                end
            end else begin
                case (state_q)
                    S_WROW: begin
                        ram_wr_d   = 1'b1;
                        ram_addr_d = {row_q, col_q};
                        ram_data_d = spi_byte;
                        col_d      = col_q + 8'd1;
                    end
                    S_CTRL: begin
                        if (first_q) begin
                            osd_enable_d = spi_byte[0];
                            hilite_en_d  = spi_byte[1];
                            first_d      = 1'b0;
                        end
                    end
                    S_HROW: begin
                        if (first_q) begin
                            hilite_row_d = spi_byte[2:0];
                            first_d      = 1'b0;
                        end
                    end
                    S_KEY: begin
                        key_code_d   = spi_byte;
                        key_strobe_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        // Deselect wins over whatever the same-cycle byte decoded to.
        if (clk7_en && !spi_vld) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            first_q      <= 1'b0;
            clearing_q   <= 1'b0;
            overrun_q    <= 1'b0;
            ram_wr_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            osd_enable_q <= 1'b0;
            hilite_en_q  <= 1'b0;
            hilite_row_q <= '0;
            key_code_q   <= '0;
            key_strobe_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            first_q      <= first_d;
            clearing_q   <= clearing_d;
            overrun_q    <= overrun_d;
            ram_wr_q     <= ram_wr_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            osd_enable_q <= osd_enable_d;
            hilite_en_q  <= hilite_en_d;
            hilite_row_q <= hilite_row_d;
            key_code_q   <= key_code_d;
            key_strobe_q <= key_strobe_d;
        end
    end

    assign spi_in     = {ID, overrun_q, clearing_q, hilite_en_q, osd_enable_q, 1'b0};
    assign ram_wr     = ram_wr_q;
    assign ram_addr   = ram_addr_q;
    assign ram_data   = ram_data_q;
    assign osd_enable = osd_enable_q;
    assign hilite_en  = hilite_en_q;
    assign hilite_row = hilite_row_q;
    assign key_code   = key_code_q;
    assign key_strobe = key_strobe_q;

endmodule

// File: tb/tb_userio_osd_cmd.sv
// Directed bench for userio_osd_cmd: vector table for single-byte effects,
// hand sequences for column wrap, row clear, deselect and reset mid-clear.
module tb_userio_osd_cmd;

    logic        clk = 1'b0;
    logic        reset, clk7_en, spi_vld, spi_rx, spi_cmd;
    logic [7:0]  spi_byte, spi_in, ram_data, key_code;
    logic        ram_wr, osd_enable, hilite_en, key_strobe;
    logic [10:0] ram_addr;
    logic [2:0]  hilite_row;

    int n_checks = 0;
    int n_pass   = 0;

    userio_osd_cmd #(.ID(3'b101)) dut (
        .clk(clk), .reset(reset), .clk7_en(clk7_en), .spi_vld(spi_vld),
        .spi_rx(spi_rx), .spi_cmd(spi_cmd), .spi_byte(spi_byte), .spi_in(spi_in),
        .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_data(ram_data),
        .osd_enable(osd_enable), .hilite_en(hilite_en), .hilite_row(hilite_row),
        .key_code(key_code), .key_strobe(key_strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         c;
        logic [7:0] b;
        bit         wr;
        logic [10:0] addr;
        logic [7:0] data;
        bit         ks;
        logic [7:0] kc;
        logic [2:0] hrow;
        logic [7:0] sin;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One byte with spi_rx held across a clk7_en period; samples the outputs
    // on the clk after the event and on the clk after that.
    task automatic send(input bit c, input logic [7:0] b, input bit vld,
                        output logic wr1, output logic [10:0] a1, output logic [7:0] d1,
                        output logic ks1, output logic wr2, output logic ks2);
        @(negedge clk);
        spi_vld = vld; spi_rx = 1'b1; spi_cmd = c; spi_byte = b; clk7_en = 1'b0;
        @(negedge clk);
        clk7_en = 1'b1;
        @(negedge clk);
        clk7_en = 1'b0;
        wr1 = ram_wr; a1 = ram_addr; d1 = ram_data; ks1 = key_strobe;
        @(negedge clk);
        wr2 = ram_wr; ks2 = key_strobe;
        spi_rx = 1'b0; spi_vld = 1'b1;
    endtask

    initial begin
        logic        wr1, wr2, ks1, ks2;
        logic [10:0] a1;
        logic [7:0]  d1, nb;
        bit          found;

        vecs[0]  = '{1'b1, 8'h23, 1'b0, 11'h000, 8'h00, 1'b0, 8'h00, 3'd0, 8'hA0};
        vecs[1]  = '{1'b0, 8'h41, 1'b1, 11'h300, 8'h41, 1'b0, 8'h00, 3'd0, 8'hA0};
        vecs[2]  = '{1'b0, 8'h42, 1'b1, 11'h301, 8'h42, 1'b0, 8'h00, 3'd0, 8'hA0};
        vecs[3]  = '{1'b1, 8'h40, 1'b0, 11'h000, 8'h00, 1'b0, 8'h00, 3'd0, 8'hA0};
        vecs[4]  = '{1'b0, 8'h03, 1'b0, 11'h000, 8'h00, 1'b0, 8'h00, 3'd0, 8'hA6};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 11'h000, 8'h00, 1'b0, 8'h00, 3'd0, 8'hA6};
        vecs[6]  = '{1'b1, 8'h41, 1'b0, 11'h000, 8'h00, 1'b0, 8'h00, 3'd0, 8'hA6};
        vecs[7]  = '{1'b0, 8'h05, 1'b0, 11'h000, 8'h00, 1'b0, 8'h00, 3'd5, 8'hA6};
        vecs[8]  = '{1'b0, 8'h02, 1'b0, 11'h000, 8'h00, 1'b0, 8'h00, 3'd5, 8'hA6};
        vecs[9]  = '{1'b1, 8'h60, 1'b0, 11'h000, 8'h00, 1'b0, 8'h00, 3'd5, 8'hA6};
        vecs[10] = '{1'b0, 8'h45, 1'b0, 11'h000, 8'h00, 1'b1, 8'h45, 3'd5, 8'hA6};
        vecs[11] = '{1'b0, 8'h12, 1'b0, 11'h000, 8'h00, 1'b1, 8'h12, 3'd5, 8'hA6};
        vecs[12] = '{1'b1, 8'h26, 1'b0, 11'h000, 8'h00, 1'b0, 8'h12, 3'd5, 8'hA6};
        vecs[13] = '{1'b0, 8'hAA, 1'b1, 11'h600, 8'hAA, 1'b0, 8'h12, 3'd5, 8'hA6};
        vecs[14] = '{1'b1, 8'h99, 1'b0, 11'h000, 8'h00, 1'b0, 8'h12, 3'd5, 8'hA6};
        vecs[15] = '{1'b0, 8'h55, 1'b0, 11'h000, 8'h00, 1'b0, 8'h12, 3'd5, 8'hA6};
        vecs[16] = '{1'b1, 8'h27, 1'b0, 11'h000, 8'h00, 1'b0, 8'h12, 3'd5, 8'hA6};

        reset = 1'b1; clk7_en = 1'b0; spi_vld = 1'b0; spi_rx = 1'b0;
        spi_cmd = 1'b0; spi_byte = '0;
        repeat (3) @(negedge clk);
        chk("rst_wr", ram_wr, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_data", ram_data, 0);
        chk("rst_spi_in", spi_in, 8'hA0);
        chk("rst_ks", key_strobe, 0);
        chk("rst_kc", key_code, 0);
        chk("rst_osd", osd_enable, 0);
        chk("rst_hilite", hilite_en, 0);
        chk("rst_hrow", hilite_row, 0);
        reset = 1'b0; spi_vld = 1'b1;

        for (int i = 0; i < 17; i++) begin
            send(vecs[i].c, vecs[i].b, 1'b1, wr1, a1, d1, ks1, wr2, ks2);
            chk($sformatf("v%0d_wr", i), wr1, vecs[i].wr);
            chk($sformatf("v%0d_wr_width", i), wr2, 0);
            if (vecs[i].wr) begin
                chk($sformatf("v%0d_addr", i), a1, vecs[i].addr);
                chk($sformatf("v%0d_data", i), d1, vecs[i].data);
            end
            chk($sformatf("v%0d_ks", i), ks1, vecs[i].ks);
            chk($sformatf("v%0d_ks_width", i), ks2, 0);
            chk($sformatf("v%0d_kc", i), key_code, vecs[i].kc);
            chk($sformatf("v%0d_hrow", i), hilite_row, vecs[i].hrow);
            chk($sformatf("v%0d_spi_in", i), spi_in, vecs[i].sin);
        end
        send(1'b0, 8'h11, 1'b1, wr1, a1, d1, ks1, wr2, ks2);
        chk("redecode_wr", wr1, 1);
        chk("redecode_addr", a1, 11'h700);

        // Column wrap within row 0.
        send(1'b1, 8'h20, 1'b1, wr1, a1, d1, ks1, wr2, ks2);
        for (int n = 0; n < 258; n++) begin
            nb = n[7:0];
            send(1'b0, nb, 1'b1, wr1, a1, d1, ks1, wr2, ks2);
            chk($sformatf("wrap%0d_wr", n), wr1, 1);
            chk($sformatf("wrap%0d_addr", n), a1, {3'd0, nb});
            chk($sformatf("wrap%0d_data", n), d1, nb);
            chk($sformatf("wrap%0d_width", n), wr2, 0);
        end

        // Row 5 clear with a command arriving mid-clear.
        @(negedge clk);
        spi_rx = 1'b1; spi_cmd = 1'b1; spi_byte = 8'h2D; clk7_en = 1'b1;
        @(negedge clk);
        spi_rx = 1'b0; clk7_en = 1'b0;
        for (int i = 0; i < 256; i++) begin
            chk("clr_wr", ram_wr, 1);
            chk("clr_addr", ram_addr, 32'h500 + i);
            chk("clr_data", ram_data, 0);
            chk("clr_busy", spi_in[3], 1);
            if (i == 10) begin spi_rx = 1'b1; spi_cmd = 1'b1; spi_byte = 8'h41; clk7_en = 1'b1; end
            if (i == 11) begin spi_rx = 1'b0; clk7_en = 1'b0; end
            @(negedge clk);
        end
        chk("clr_end_wr", ram_wr, 0);
        chk("clr_end_spi_in", spi_in, 8'hB6);
        send(1'b0, 8'h03, 1'b1, wr1, a1, d1, ks1, wr2, ks2);
        chk("post_clr_wr", wr1, 0);
        chk("post_clr_hrow", hilite_row, 3'd5);
        send(1'b1, 8'h81, 1'b1, wr1, a1, d1, ks1, wr2, ks2);
        chk("ovr_clear_spi_in", spi_in, 8'hA6);

        // Key injection, then deselect discards the key state.
        send(1'b1, 8'h60, 1'b1, wr1, a1, d1, ks1, wr2, ks2);
        send(1'b0, 8'h33, 1'b1, wr1, a1, d1, ks1, wr2, ks2);
        chk("key_ks", ks1, 1);
        chk("key_kc", key_code, 8'h33);
        @(negedge clk); spi_vld = 1'b0; clk7_en = 1'b1;
        @(negedge clk); spi_vld = 1'b1; clk7_en = 1'b0;
        send(1'b0, 8'h44, 1'b1, wr1, a1, d1, ks1, wr2, ks2);
        chk("desel_ks", ks1, 0);
        chk("desel_wr", wr1, 0);
        chk("desel_kc", key_code, 8'h33);
        chk("desel_spi_in", spi_in, 8'hA6);
        send(1'b1, 8'h60, 1'b0, wr1, a1, d1, ks1, wr2, ks2);
        send(1'b0, 8'h55, 1'b1, wr1, a1, d1, ks1, wr2, ks2);
        chk("cmd_desel_ks", ks1, 0);
        chk("cmd_desel_kc", key_code, 8'h33);

        // Reset at clear column 0x40 (row 3), with overrun set beforehand.
        @(negedge clk);
        spi_rx = 1'b1; spi_cmd = 1'b1; spi_byte = 8'h2B; clk7_en = 1'b1;
        found = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin spi_rx = 1'b0; clk7_en = 1'b0; end
            if (cyc == 5) begin spi_rx = 1'b1; spi_cmd = 1'b0; spi_byte = 8'h77; clk7_en = 1'b1; end
            if (cyc == 6) begin spi_rx = 1'b0; clk7_en = 1'b0; end
            if (ram_wr && ram_addr == 11'h340) begin found = 1'b1; break; end
        end
        chk("rst_clr_found", found, 1);
        chk("rst_clr_ovr_set", spi_in, 8'hBE);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_clr_wr", ram_wr, 0);
        chk("rst_clr_addr", ram_addr, 0);
        chk("rst_clr_data", ram_data, 0);
        chk("rst_clr_spi_in", spi_in, 8'hA0);
        chk("rst_clr_kc", key_code, 0);
        chk("rst_clr_hrow", hilite_row, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_clr_wr_after", ram_wr, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
